// File: rtl/instr_decode_seq.sv
// Handshaked instruction-class decoder: turns an opcode byte (plus an optional trailing
// immediate byte) into a registered one-hot class, with valid/ready flow control and a retire counter.
module instr_decode_seq #(
    parameter int DATA_W      = 8,
    parameter int CLASS_W     = 2,
    parameter int NUM_CLASSES = 4,
    parameter int IMM_EN      = 1,
    parameter int IMM_CLASS   = 0,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CLASSES-1:0]    out_class,
    output logic [DATA_W-CLASS_W-1:0] out_field,
    output logic [DATA_W-1:0]         out_imm,
    output logic                      out_has_imm,
    output logic                      out_illegal,
    output logic [CNT_W-1:0]          instr_count
);

    localparam int FIELD_W = DATA_W - CLASS_W;

    typedef enum logic {S_OP, S_IMM} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pend_q, pend_d;
    logic                vld_d;
    logic                load;
    logic [DATA_W-1:0]   dec_src;
    logic [DATA_W-1:0]   imm_d;
    logic                has_imm_d;
    logic                slot_free, in_fire, out_fire;

    function automatic logic [CLASS_W-1:0] cls_of(input logic [DATA_W-1:0] d);
        return d[DATA_W-1 -: CLASS_W];
    endfunction

    function automatic logic [NUM_CLASSES-1:0] class_onehot(input logic [CLASS_W-1:0] c);
        logic [NUM_CLASSES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (c == CLASS_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Folds to constant 0 when every class index is legal.
    function automatic logic class_illegal(input logic [CLASS_W-1:0] c);
        return int'(c) >= NUM_CLASSES;
    endfunction

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        vld_d     = out_valid && !out_fire;
        load      = 1'b0;
        dec_src   = in_data;
        imm_d     = '0;
        has_imm_d = 1'b0;
        if (flush) begin
            state_d = S_OP;
            pend_d  = '0;
            vld_d   = 1'b0;
        end else if (in_fire) begin
            case (state_q)
                S_OP: begin
                    if (IMM_EN != 0 && cls_of(in_data) == CLASS_W'(IMM_CLASS)) begin
                        pend_d  = in_data;
                        state_d = S_IMM;
                    end else begin
                        load = 1'b1;
                    end
                end
                S_IMM: begin
                    load      = 1'b1;
                    dec_src   = pend_q;
                    imm_d     = in_data;
                    has_imm_d = 1'b1;
                    state_d   = S_OP;
                end
            endcase
            if (load) vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_OP;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Output stage: registered decode presented to the execute stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_class   <= '0;
            out_field   <= '0;
            out_imm     <= '0;
            out_has_imm <= 1'b0;
            out_illegal <= 1'b0;
            instr_count <= '0;
        end else begin
            out_valid <= vld_d;
            if (load) begin
                out_class   <= class_illegal(cls_of(dec_src)) ? '0 : class_onehot(cls_of(dec_src));
                out_illegal <= class_illegal(cls_of(dec_src));
                out_field   <= dec_src[FIELD_W-1:0];
                out_imm     <= imm_d;
                out_has_imm <= has_imm_d;
            end
            if (out_fire) instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_decode_seq.sv
// Bench for instr_decode_seq: default instance (a) and a 3-class, 4-bit-counter instance (b),
// each checked against a queue of expected decodes.
module tb_instr_decode_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic [7:0] a_in_data;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0] a_out_class;
    logic [5:0] a_out_field;
    logic [7:0] a_out_imm;
    logic       a_out_has_imm, a_out_illegal;
    logic [7:0] a_instr_count;

    logic [7:0] b_in_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0] b_out_class;
    logic [5:0] b_out_field;
    logic [7:0] b_out_imm;
    logic       b_out_has_imm, b_out_illegal;
    logic [3:0] b_instr_count;

    instr_decode_seq u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_class(a_out_class), .out_field(a_out_field), .out_imm(a_out_imm),
        .out_has_imm(a_out_has_imm), .out_illegal(a_out_illegal),
        .instr_count(a_instr_count)
    );

    instr_decode_seq #(.NUM_CLASSES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_class(b_out_class), .out_field(b_out_field), .out_imm(b_out_imm),
        .out_has_imm(b_out_has_imm), .out_illegal(b_out_illegal),
        .instr_count(b_instr_count)
    );

    typedef struct packed {
        logic [3:0] cls;
        logic [5:0] field;
        logic [7:0] imm;
        logic       has_imm;
        logic       illegal;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cnt_a = 0, cnt_b = 0;
    logic       ms_a = 1'b0, ms_b = 1'b0;
    logic [7:0] pend_a = '0, pend_b = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t decode(input logic [7:0] op, input logic [7:0] imm,
                                    input logic has, input int nc);
        exp_t e;
        int   c;
        c         = int'(op[7:6]);
        e.cls     = (c < nc) ? 4'(1 << c) : 4'b0000;
        e.illegal = (c >= nc);
        e.field   = op[5:0];
        e.imm     = has ? imm : 8'h00;
        e.has_imm = has;
        return e;
    endfunction

    // Scoreboard: push on accepted final byte, pop on each output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            cnt_a = 0; cnt_b = 0; ms_a = 1'b0; ms_b = 1'b0;
            q_a.delete(); q_b.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) chk("sb_a_unexpected", 32'(a_out_valid), 32'd0);
                else chk("sb_a", 32'(exp_t'({a_out_class, a_out_field, a_out_imm,
                                              a_out_has_imm, a_out_illegal})), 32'(q_a.pop_front()));
                chk("cnt_a", 32'(a_instr_count), 32'(cnt_a & 255));
                cnt_a++;
            end
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) chk("sb_b_unexpected", 32'(b_out_valid), 32'd0);
                else chk("sb_b", 32'(exp_t'({1'b0, b_out_class, b_out_field, b_out_imm,
                                              b_out_has_imm, b_out_illegal})), 32'(q_b.pop_front()));
                chk("cnt_b", 32'(b_instr_count), 32'(cnt_b & 15));
                cnt_b++;
            end
            if (flush) begin
                ms_a = 1'b0; ms_b = 1'b0;
            end else begin
                if (a_in_valid && a_in_ready) begin
                    if (ms_a) begin q_a.push_back(decode(pend_a, a_in_data, 1'b1, 4)); ms_a = 1'b0; end
                    else if (a_in_data[7:6] == 2'd0) begin pend_a = a_in_data; ms_a = 1'b1; end
                    else q_a.push_back(decode(a_in_data, 8'h00, 1'b0, 4));
                end
                if (b_in_valid && b_in_ready) begin
                    if (ms_b) begin q_b.push_back(decode(pend_b, b_in_data, 1'b1, 3)); ms_b = 1'b0; end
                    else if (b_in_data[7:6] == 2'd0) begin pend_b = b_in_data; ms_b = 1'b1; end
                    else q_b.push_back(decode(b_in_data, 8'h00, 1'b0, 3));
                end
            end
        end
    end

    task automatic send(input bit sel_b, input logic [7:0] d);
        int n;
        n = 0;
        if (sel_b) begin b_in_data = d; b_in_valid = 1'b1; end
        else begin a_in_data = d; a_in_valid = 1'b1; end
        @(negedge clk);
        while (!(sel_b ? b_in_ready : a_in_ready) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("send_timeout", 32'(sel_b ? b_in_ready : a_in_ready), 32'd1);
        @(posedge clk); #1;
        if (sel_b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int         k;
        rst = 1'b0; flush = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_class", 32'(a_out_class), 32'd0);
        chk("rst_count", 32'(a_instr_count), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // single Copy opcode
        send(1'b0, 8'h45);
        chk("t1_valid", 32'(a_out_valid), 32'd1);
        chk("t1_class", 32'(a_out_class), 32'b0010);
        chk("t1_field", 32'(a_out_field), 32'h05);
        chk("t1_illegal", 32'(a_out_illegal), 32'd0);
        chk("t1_has_imm", 32'(a_out_has_imm), 32'd0);
        chk("t1_count0", 32'(a_instr_count), 32'd0);
        @(posedge clk); #1;
        chk("t1_count1", 32'(a_instr_count), 32'd1);
        chk("t1_valid_fall", 32'(a_out_valid), 32'd0);

        // load-immediate pair
        send(1'b0, 8'h03);
        chk("t2_no_out", 32'(a_out_valid), 32'd0);
        send(1'b0, 8'h7F);
        chk("t2_class", 32'(a_out_class), 32'b0001);
        chk("t2_field", 32'(a_out_field), 32'h03);
        chk("t2_imm", 32'(a_out_imm), 32'h7F);
        chk("t2_has_imm", 32'(a_out_has_imm), 32'd1);

        // back-to-back
        send(1'b0, 8'h80);
        chk("t3_class_a", 32'(a_out_class), 32'b0100);
        chk("t3_in_ready", 32'(a_in_ready), 32'd1);
        send(1'b0, 8'hC2);
        chk("t3_class_b", 32'(a_out_class), 32'b1000);
        chk("t3_valid", 32'(a_out_valid), 32'd1);
        @(posedge clk); #1;

        // backpressure hold
        a_out_ready = 1'b0;
        send(1'b0, 8'h45);
        a_in_data = 8'h81; a_in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(a_out_valid), 32'd1);
            chk("t4_hold_class", 32'(a_out_class), 32'b0010);
            chk("t4_hold_field", 32'(a_out_field), 32'h05);
            chk("t4_in_ready", 32'(a_in_ready), 32'd0);
        end
        chk("t4_count_held", 32'(a_instr_count), 32'd4);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        #1;
        chk("t4_in_ready_rel", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("t4_count", 32'(a_instr_count), 32'd5);
        chk("t4_next_class", 32'(a_out_class), 32'b0100);

        // flush in S_IMM
        send(1'b0, 8'h03);
        flush = 1'b1; a_in_data = 8'h55; a_in_valid = 1'b1;
        #1;
        chk("t5_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; a_in_valid = 1'b0;
        chk("t5_no_out", 32'(a_out_valid), 32'd0);
        send(1'b0, 8'h41);
        chk("t5_class", 32'(a_out_class), 32'b0010);
        chk("t5_field", 32'(a_out_field), 32'h01);
        chk("t5_has_imm", 32'(a_out_has_imm), 32'd0);

        // reset mid-S_IMM
        send(1'b0, 8'h03);
        rst = 1'b0;
        #1;
        chk("t6_rst_outs", 32'({a_out_valid, a_out_class, a_out_field, a_out_imm,
                                a_out_has_imm, a_out_illegal}), 32'd0);
        chk("t6_rst_count", 32'(a_instr_count), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        send(1'b0, 8'hC2);
        chk("t6_class", 32'(a_out_class), 32'b1000);
        chk("t6_has_imm", 32'(a_out_has_imm), 32'd0);
        @(posedge clk); #1;
        chk("t6_count", 32'(a_instr_count), 32'd1);

        // flush coinciding with an output transfer still counts
        a_out_ready = 1'b0;
        send(1'b0, 8'h45);
        flush = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t7_count", 32'(a_instr_count), 32'd2);
        chk("t7_valid", 32'(a_out_valid), 32'd0);
        chk("drain_a", 32'(q_a.size()), 32'd0);

        // illegal class and 4-bit counter wrap
        send(1'b1, 8'hC1);
        chk("b_class", 32'(b_out_class), 32'b000);
        chk("b_illegal", 32'(b_out_illegal), 32'd1);
        chk("b_field", 32'(b_out_field), 32'h01);
        k = 0;
        while (k < 16) begin
            if ($urandom_range(0, 1) == 1) begin
                b_out_ready = 1'b0;
                @(posedge clk); #1;
                b_out_ready = 1'b1;
            end
            d = 8'($urandom_range(0, 255));
            send(1'b1, d);
            if (d[7:6] == 2'd0) send(1'b1, 8'($urandom_range(0, 255)));
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("b_wrap_count", 32'(b_instr_count), 32'd1);
        chk("drain_b", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
